// File: rtl/mem_bus_pkg.sv
// Shared constants, region/state types and address helpers for the mem_bus slice.
// The OAM DMA engine is built only when MMU_OAM_DMA_EN is defined.
package mem_bus_pkg;

    localparam logic [15:0] HRAM_LO  = 16'hFF80;
    localparam logic [15:0] HRAM_HI  = 16'hFFFE;
    localparam logic [15:0] IE_ADDR  = 16'hFFFF;
    localparam logic [15:0] DMA_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE = 16'hFE00;

    localparam int HRAM_DEPTH = 127;

    localparam int DMA_BYTES         = 160;
    localparam int DMA_CLKS_PER_BYTE = 4;

    // Source pages E0-FF alias the work RAM echo, so they fold down by 0x20.
    localparam logic [7:0] ECHO_PAGE_LO = 8'hE0;
    localparam logic [7:0] ECHO_OFFSET  = 8'h20;

    typedef enum logic [2:0] {
        REG_EXT,
        REG_HRAM,
        REG_IE,
        REG_DMA,
        REG_BLOCKED
    } region_t;

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_START,
        DMA_XFER
    } dma_state_t;

    function automatic region_t decode_region(input logic [15:0] addr, input logic dma_reg_en);
        region_t r;
        r = REG_EXT;
        if (addr >= HRAM_LO && addr <= HRAM_HI) r = REG_HRAM;
        else if (addr == IE_ADDR)               r = REG_IE;
        else if (dma_reg_en && addr == DMA_ADDR) r = REG_DMA;
        return r;
    endfunction

    function automatic logic [7:0] dma_src_page(input logic [7:0] v);
        return (v >= ECHO_PAGE_LO) ? v - ECHO_OFFSET : v;
    endfunction

endpackage

// File: rtl/mem_bus_if.sv
// CPU-side and external-side signal bundle of the memory-bus stage.
// The mem_bus stage is the slave; the CPU core plus external memory act as master.
interface mem_bus_if;

    logic [15:0] cpu_rd_addr;
    logic [7:0]  cpu_rd_data;
    logic        cpu_wr_en;
    logic [15:0] cpu_wr_addr;
    logic [7:0]  cpu_wr_data;
    logic [15:0] ext_rd_addr;
    logic [7:0]  ext_rd_data;
    logic        ext_wr_en;
    logic [15:0] ext_wr_addr;
    logic [7:0]  ext_wr_data;
    logic        dma_active;

    modport master (
        output cpu_rd_addr, cpu_wr_en, cpu_wr_addr, cpu_wr_data, ext_rd_data,
        input  cpu_rd_data, ext_rd_addr, ext_wr_en, ext_wr_addr, ext_wr_data, dma_active
    );

    modport slave (
        input  cpu_rd_addr, cpu_wr_en, cpu_wr_addr, cpu_wr_data, ext_rd_data,
        output cpu_rd_data, ext_rd_addr, ext_wr_en, ext_wr_addr, ext_wr_data, dma_active
    );

endinterface

// File: rtl/mem_bus_hram_ram.sv
// High RAM (FF80-FFFE): 127x8, one write port and one synchronous read port.
// A read and a write to the same word in one clock return the old contents.
module hram_ram
    import mem_bus_pkg::*;
(
    input  logic       clk,
    input  logic       wr_en,
    input  logic [6:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data
);

    logic [7:0] mem [HRAM_DEPTH];

    // NOTE: storage is deliberately left out of reset so it maps onto a RAM macro.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/mem_bus.sv
// Memory-bus stage behind the CPU: HRAM, IE and FF46 decode, external forwarding,
// and the OAM DMA engine (present only when MMU_OAM_DMA_EN is defined).
module mem_bus
    import mem_bus_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    mem_bus_if.slave bus
);

`ifdef MMU_OAM_DMA_EN
    localparam logic DMA_EN = 1'b1;
`else
    localparam logic DMA_EN = 1'b0;
`endif

    region_t     rd_region;
    region_t     wr_region;
    region_t     rd_tag;
    logic        rd_valid;
    logic [7:0]  ie_q;
    logic [7:0]  hram_q;

    logic        dma_busy;
    logic [7:0]  dma_reg_rd;
    logic        dma_rd_en;
    logic [15:0] dma_rd_addr;
    logic        dma_wr_en;
    logic [15:0] dma_wr_addr;
    logic [7:0]  dma_wr_data;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rd_region = decode_region(bus.cpu_rd_addr, DMA_EN);
        if (dma_busy && rd_region == REG_EXT) rd_region = REG_BLOCKED;
        wr_region = decode_region(bus.cpu_wr_addr, DMA_EN);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_tag   <= REG_EXT;
            rd_valid <= 1'b0;
        end else begin
            rd_tag   <= rd_region;
            rd_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                      ie_q <= '0;
        else if (bus.cpu_wr_en && wr_region == REG_IE)  ie_q <= bus.cpu_wr_data;
    end

    hram_ram u_hram (
        .clk     (clk),
        .wr_en   (bus.cpu_wr_en && wr_region == REG_HRAM),
        .wr_addr (bus.cpu_wr_addr[6:0]),
        .wr_data (bus.cpu_wr_data),
        .rd_addr (bus.cpu_rd_addr[6:0]),
        .rd_data (hram_q)
    );

    // Read data is muxed from last clock's tag, so every region has the same latency.
    always_comb begin
        bus.cpu_rd_data = '0;
        if (rd_valid) begin
            case (rd_tag)
                REG_HRAM:    bus.cpu_rd_data = hram_q;
                REG_IE:      bus.cpu_rd_data = ie_q;
                REG_DMA:     bus.cpu_rd_data = dma_reg_rd;
                REG_BLOCKED: bus.cpu_rd_data = 8'hFF;
                default:     bus.cpu_rd_data = bus.ext_rd_data;
            endcase
        end
    end

    assign bus.ext_rd_addr = dma_rd_en ? dma_rd_addr : bus.cpu_rd_addr;
    assign bus.dma_active  = dma_busy;

    always_comb begin
        bus.ext_wr_en   = 1'b0;
        bus.ext_wr_addr = '0;
        bus.ext_wr_data = '0;
        if (dma_wr_en) begin
            bus.ext_wr_en   = 1'b1;
            bus.ext_wr_addr = dma_wr_addr;
            bus.ext_wr_data = dma_wr_data;
        end else if (bus.cpu_wr_en && wr_region == REG_EXT && !dma_busy) begin
            bus.ext_wr_en   = 1'b1;
            bus.ext_wr_addr = bus.cpu_wr_addr;
            bus.ext_wr_data = bus.cpu_wr_data;
        end
    end

`ifdef MMU_OAM_DMA_EN
    localparam int PH_W  = $clog2(DMA_CLKS_PER_BYTE);
    localparam int CNT_W = $clog2(DMA_BYTES);

    localparam logic [PH_W-1:0]  PH_READ  = PH_W'(0);
    localparam logic [PH_W-1:0]  PH_LATCH = PH_W'(1);
    localparam logic [PH_W-1:0]  PH_WRITE = PH_W'(2);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DMA_CLKS_PER_BYTE - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DMA_BYTES - 1);

    dma_state_t       state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       dma_reg_q;
    logic [7:0]       dma_data_q;
    logic             dma_start;

    assign dma_start = bus.cpu_wr_en && wr_region == REG_DMA;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= DMA_IDLE;
            phase_q    <= '0;
            count_q    <= '0;
            dma_reg_q  <= '0;
            dma_data_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            count_q <= count_d;
            if (dma_start) dma_reg_q <= bus.cpu_wr_data;
            if (state_q == DMA_XFER && phase_q == PH_LATCH) dma_data_q <= bus.ext_rd_data;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        count_d = count_q;
        case (state_q)
            DMA_START: begin
                if (phase_q == PH_LAST) begin
                    state_d = DMA_XFER;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            DMA_XFER: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (count_q == CNT_LAST) begin
                        state_d = DMA_IDLE;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            default: state_d = DMA_IDLE;
        endcase
        // A new FF46 write always wins, even mid-transfer.
        if (dma_start) begin
            state_d = DMA_START;
            phase_d = '0;
            count_d = '0;
        end
    end

    assign dma_busy    = (state_q != DMA_IDLE);
    assign dma_reg_rd  = dma_reg_q;
    assign dma_rd_en   = (state_q == DMA_XFER) && (phase_q == PH_READ);
    assign dma_rd_addr = {dma_src_page(dma_reg_q), 8'h00} + 16'(count_q);
    assign dma_wr_en   = (state_q == DMA_XFER) && (phase_q == PH_WRITE);
    assign dma_wr_addr = OAM_BASE + 16'(count_q);
    assign dma_wr_data = dma_data_q;
`else
    assign dma_busy    = 1'b0;
    assign dma_reg_rd  = '0;
    assign dma_rd_en   = 1'b0;
    assign dma_rd_addr = '0;
    assign dma_wr_en   = 1'b0;
    assign dma_wr_addr = '0;
    assign dma_wr_data = '0;
`endif

endmodule

// File: tb/tb_mem_bus.sv
// Self-checking bench for mem_bus: random traffic against a flat memory-map model,
// plus OAM DMA scenarios when MMU_OAM_DMA_EN is defined.
module tb_mem_bus;

    localparam int K  = 4;    // clocks per DMA byte
    localparam int NB = 160;  // bytes per DMA

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic clk;
    logic rst_n;
    mem_bus_if bus();

    mem_bus dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    logic [7:0] ext_mem [65536];
    logic [7:0] hram_m  [127];
    logic [7:0] ie_m;
    logic [7:0] dma_m;

    wr_t wr_log[$];
    wr_t exp_log[$];
    int  cyc = 0;
    int  active_cnt = 0;
    int  n_checks = 0;
    int  n_fail = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bus.ext_rd_data <= ext_mem[bus.ext_rd_addr];

    always @(negedge clk) begin
        if (bus.ext_wr_en) begin
            wr_t w;
            w.cyc = cyc; w.addr = bus.ext_wr_addr; w.data = bus.ext_wr_data;
            wr_log.push_back(w);
        end
        if (bus.dma_active) active_cnt++;
    end

    task automatic drive(input logic [15:0] ra, input logic we, input logic [15:0] wa, input logic [7:0] wd);
        bus.cpu_rd_addr = ra; bus.cpu_wr_en = we; bus.cpu_wr_addr = wa; bus.cpu_wr_data = wd;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle_until(input int c);
        while (cyc < c) begin drive(16'h0000, 1'b0, 16'h0000, 8'h00); step(); end
    endtask

    // Expected DMA writes: K clocks of START, then byte k written in phase 2 of its slot.
    function automatic void add_expected(input int t0, input logic [7:0] v, input int nbytes);
        logic [15:0] src;
        src = {(v >= 8'hE0) ? v - 8'h20 : v, 8'h00};
        for (int k = 0; k < nbytes; k++) begin
            wr_t e;
            e.cyc = t0 + 1 + K + K * k + 2;
            e.addr = 16'hFE00 + 16'(k);
            e.data = ext_mem[src + 16'(k)];
            exp_log.push_back(e);
        end
    endfunction

    function automatic logic [7:0] model_read(input logic [15:0] a);
        if (a >= 16'hFF80 && a <= 16'hFFFE) return hram_m[a - 16'hFF80];
        if (a == 16'hFFFF) return ie_m;
`ifdef MMU_OAM_DMA_EN
        if (a == 16'hFF46) return dma_m;
`endif
        return ext_mem[a];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        drive(16'h0000, 1'b0, 16'h0000, 8'h00);
        repeat (3) step();
        n_checks++; if (bus.cpu_rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got=%h exp=00", bus.cpu_rd_data); end
        n_checks++; if (bus.ext_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got=%b exp=0", bus.ext_wr_en); end
        n_checks++; if (bus.ext_wr_addr !== 16'h0000 || bus.ext_wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_bus got=%h/%h exp=0000/00", bus.ext_wr_addr, bus.ext_wr_data); end
        n_checks++; if (bus.dma_active !== 1'b0) begin n_fail++; $display("FAIL reset_dma_active got=%b exp=0", bus.dma_active); end
        rst_n = 1'b1;
        ie_m = 8'h00; dma_m = 8'h00;
        drive(16'hFFFF, 1'b0, 16'h0000, 8'h00); step();
        n_checks++; if (bus.cpu_rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_ie got=%h exp=00", bus.cpu_rd_data); end
    endtask

    task automatic test_hram();
        for (int i = 0; i < 127; i++) begin
            hram_m[i] = 8'($urandom);
            drive(16'h0000, 1'b1, 16'hFF80 + 16'(i), hram_m[i]); step();
        end
        hram_m[16] = 8'hA5;
        drive(16'h0000, 1'b1, 16'hFF90, 8'hA5); step();
        for (int i = 0; i < 127; i++) begin
            drive(16'hFF80 + 16'(i), 1'b0, 16'h0000, 8'h00); step();
            n_checks++; if (bus.cpu_rd_data !== hram_m[i]) begin n_fail++; $display("FAIL hram_read[%0d] got=%h exp=%h", i, bus.cpu_rd_data, hram_m[i]); end
        end
    endtask

    task automatic test_ext_read();
        ext_mem[16'h0150] = 8'h3C;
        drive(16'h0150, 1'b0, 16'h0000, 8'h00); #1;
        n_checks++; if (bus.ext_rd_addr !== 16'h0150) begin n_fail++; $display("FAIL ext_rd_addr got=%h exp=0150", bus.ext_rd_addr); end
        step();
        n_checks++; if (bus.cpu_rd_data !== 8'h3C) begin n_fail++; $display("FAIL ext_read got=%h exp=3C", bus.cpu_rd_data); end
    endtask

    task automatic test_same_addr();
        logic [7:0] nv;
        nv = ~hram_m[32];
        drive(16'hFFA0, 1'b1, 16'hFFA0, nv); step();
        n_checks++; if (bus.cpu_rd_data !== hram_m[32]) begin n_fail++; $display("FAIL same_addr_old got=%h exp=%h", bus.cpu_rd_data, hram_m[32]); end
        hram_m[32] = nv;
        drive(16'hFFA0, 1'b0, 16'h0000, 8'h00); step();
        n_checks++; if (bus.cpu_rd_data !== nv) begin n_fail++; $display("FAIL same_addr_new got=%h exp=%h", bus.cpu_rd_data, nv); end
    endtask

    task automatic test_ie();
        drive(16'h0000, 1'b1, 16'hFFFF, 8'h5A); step();
        ie_m = 8'h5A;
        drive(16'hFFFF, 1'b0, 16'h0000, 8'h00); step();
        n_checks++; if (bus.cpu_rd_data !== 8'h5A) begin n_fail++; $display("FAIL ie_read got=%h exp=5A", bus.cpu_rd_data); end
    endtask

    task automatic test_random();
        logic        pending;
        logic [7:0]  exp_rd;
        logic [15:0] ra, wa;
        logic [7:0]  wd;
        logic        we, ext_we;
        int          sel;
        pending = 1'b0; exp_rd = 8'h00;
        for (int it = 0; it < 300; it++) begin
            if (pending) begin
                n_checks++; if (bus.cpu_rd_data !== exp_rd) begin n_fail++; $display("FAIL rand_read it=%0d got=%h exp=%h", it, bus.cpu_rd_data, exp_rd); end
            end
            sel = $urandom_range(0, 9);
            if (sel < 5)       ra = 16'hFF80 + 16'($urandom_range(0, 126));
            else if (sel == 5) ra = 16'hFFFF;
            else if (sel == 6) ra = 16'hFF46;
            else               ra = 16'($urandom_range(0, 16'hFF7F));
            exp_rd = model_read(ra);
            pending = 1'b1;
            sel = $urandom_range(0, 9);
            we = (sel < 7); ext_we = 1'b0; wd = 8'($urandom);
            if (sel < 4) wa = 16'hFF80 + 16'($urandom_range(0, 126));
            else begin
                wa = 16'($urandom_range(0, 16'hFF7F));
`ifdef MMU_OAM_DMA_EN
                if (wa == 16'hFF46) wa = 16'hFF47;
`endif
                ext_we = we;
            end
            if (we && sel < 4) hram_m[wa - 16'hFF80] = wd;
            drive(ra, we, wa, wd); #1;
            n_checks++; if (bus.ext_rd_addr !== ra) begin n_fail++; $display("FAIL rand_ext_rd_addr got=%h exp=%h", bus.ext_rd_addr, ra); end
            n_checks++; if (bus.ext_wr_en !== ext_we) begin n_fail++; $display("FAIL rand_ext_wr_en got=%b exp=%b", bus.ext_wr_en, ext_we); end
            if (ext_we) begin
                n_checks++; if (bus.ext_wr_addr !== wa || bus.ext_wr_data !== wd) begin n_fail++; $display("FAIL rand_ext_wr got=%h/%h exp=%h/%h", bus.ext_wr_addr, bus.ext_wr_data, wa, wd); end
            end
            step();
        end
        n_checks++; if (bus.cpu_rd_data !== exp_rd) begin n_fail++; $display("FAIL rand_read_last got=%h exp=%h", bus.cpu_rd_data, exp_rd); end
        drive(16'h0000, 1'b0, 16'h0000, 8'h00); step();
    endtask

`ifdef MMU_OAM_DMA_EN
    task automatic test_dma();
        int t0;
        wr_log.delete(); exp_log.delete(); active_cnt = 0;
        t0 = cyc;
        drive(16'h0000, 1'b1, 16'hFF46, 8'hC1); step();
        dma_m = 8'hC1;
        add_expected(t0, 8'hC1, NB);
        idle_until(t0 + 19);
        drive(16'hC000, 1'b1, 16'hD000, 8'h99); #1;
        n_checks++; if (bus.ext_wr_addr !== 16'hFE03) begin n_fail++; $display("FAIL dma_cpu_wr_dropped got=%h exp=FE03", bus.ext_wr_addr); end
        step();
        n_checks++; if (bus.cpu_rd_data !== 8'hFF) begin n_fail++; $display("FAIL dma_blocked_read got=%h exp=FF", bus.cpu_rd_data); end
        drive(16'hFF46, 1'b1, 16'hFF80, 8'h77); step();
        hram_m[0] = 8'h77;
        n_checks++; if (bus.cpu_rd_data !== 8'hC1) begin n_fail++; $display("FAIL dma_reg_read got=%h exp=C1", bus.cpu_rd_data); end
        drive(16'hFF80, 1'b0, 16'h0000, 8'h00); step();
        n_checks++; if (bus.cpu_rd_data !== 8'h77) begin n_fail++; $display("FAIL dma_hram_read got=%h exp=77", bus.cpu_rd_data); end
        n_checks++; if (bus.dma_active !== 1'b1) begin n_fail++; $display("FAIL dma_active_mid got=%b exp=1", bus.dma_active); end
        idle_until(t0 + 660);
        n_checks++; if (wr_log.size() != exp_log.size()) begin n_fail++; $display("FAIL dma_count got=%0d exp=%0d", wr_log.size(), exp_log.size()); end
        for (int i = 0; i < exp_log.size() && i < wr_log.size(); i++) begin
            n_checks++;
            if (wr_log[i].cyc != exp_log[i].cyc || wr_log[i].addr !== exp_log[i].addr || wr_log[i].data !== exp_log[i].data) begin
                n_fail++; $display("FAIL dma_write[%0d] got=%0d/%h/%h exp=%0d/%h/%h", i, wr_log[i].cyc - t0, wr_log[i].addr, wr_log[i].data, exp_log[i].cyc - t0, exp_log[i].addr, exp_log[i].data);
            end
        end
        n_checks++; if (active_cnt != 1 + K + NB * K - 1) begin n_fail++; $display("FAIL dma_active_len got=%0d exp=%0d", active_cnt, 1 + K + NB * K - 1); end
        n_checks++; if (bus.dma_active !== 1'b0) begin n_fail++; $display("FAIL dma_active_end got=%b exp=0", bus.dma_active); end
    endtask

    task automatic test_dma_restart();
        int t0, r;
        wr_log.delete(); exp_log.delete(); active_cnt = 0;
        t0 = cyc;
        drive(16'h0000, 1'b1, 16'hFF46, 8'hC1); step();
        add_expected(t0, 8'hC1, 50);
        idle_until(t0 + 1 + K + K * 50);
        r = cyc;
        drive(16'h0000, 1'b1, 16'hFF46, 8'hC2); step();
        dma_m = 8'hC2;
        add_expected(r, 8'hC2, NB);
        idle_until(r + 660);
        n_checks++; if (wr_log.size() != 50 + NB) begin n_fail++; $display("FAIL restart_count got=%0d exp=%0d", wr_log.size(), 50 + NB); end
        for (int i = 0; i < exp_log.size() && i < wr_log.size(); i++) begin
            n_checks++;
            if (wr_log[i].cyc != exp_log[i].cyc || wr_log[i].addr !== exp_log[i].addr || wr_log[i].data !== exp_log[i].data) begin
                n_fail++; $display("FAIL restart_write[%0d] got=%h/%h exp=%h/%h", i, wr_log[i].addr, wr_log[i].data, exp_log[i].addr, exp_log[i].data);
            end
        end
        n_checks++; if (active_cnt != (r - t0) + K + NB * K) begin n_fail++; $display("FAIL restart_active_len got=%0d exp=%0d", active_cnt, (r - t0) + K + NB * K); end
    endtask

    task automatic test_dma_echo();
        int t0;
        logic [7:0] v;
        v = 8'($urandom_range(8'hE0, 8'hFF));
        wr_log.delete(); exp_log.delete();
        t0 = cyc;
        drive(16'h0000, 1'b1, 16'hFF46, v); step();
        dma_m = v;
        add_expected(t0, v, NB);
        idle_until(t0 + 660);
        n_checks++; if (wr_log.size() != NB) begin n_fail++; $display("FAIL echo_count got=%0d exp=%0d", wr_log.size(), NB); end
        for (int i = 0; i < exp_log.size() && i < wr_log.size(); i++) begin
            n_checks++;
            if (wr_log[i].addr !== exp_log[i].addr || wr_log[i].data !== exp_log[i].data) begin
                n_fail++; $display("FAIL echo_write[%0d] v=%h got=%h/%h exp=%h/%h", i, v, wr_log[i].addr, wr_log[i].data, exp_log[i].addr, exp_log[i].data);
            end
        end
    endtask

    task automatic test_reset_mid_dma();
        int t0;
        drive(16'h0000, 1'b1, 16'hFFFF, 8'h1F); step();
        wr_log.delete();
        t0 = cyc;
        drive(16'h0000, 1'b1, 16'hFF46, 8'hC3); step();
        idle_until(t0 + 1 + K + K * 10 + 2);
        n_checks++; if (bus.ext_wr_en !== 1'b1) begin n_fail++; $display("FAIL mid_dma_wr_en got=%b exp=1", bus.ext_wr_en); end
        rst_n = 1'b0; #1;
        n_checks++; if (bus.dma_active !== 1'b0) begin n_fail++; $display("FAIL rst_dma_active got=%b exp=0", bus.dma_active); end
        n_checks++; if (bus.ext_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en got=%b exp=0", bus.ext_wr_en); end
        repeat (3) step();
        rst_n = 1'b1;
        ie_m = 8'h00; dma_m = 8'h00;
        idle_until(cyc + 40);
        n_checks++; if (wr_log.size() != 10) begin n_fail++; $display("FAIL rst_write_count got=%0d exp=10", wr_log.size()); end
        drive(16'hFFFF, 1'b0, 16'h0000, 8'h00); step();
        n_checks++; if (bus.cpu_rd_data !== 8'h00) begin n_fail++; $display("FAIL rst_ie got=%h exp=00", bus.cpu_rd_data); end
        drive(16'hFF46, 1'b0, 16'h0000, 8'h00); step();
        n_checks++; if (bus.cpu_rd_data !== 8'h00) begin n_fail++; $display("FAIL rst_dma_reg got=%h exp=00", bus.cpu_rd_data); end
    endtask
`else
    task automatic test_ff46_forward();
        active_cnt = 0;
        drive(16'hFF46, 1'b1, 16'hFF46, 8'hC1); #1;
        n_checks++; if (bus.ext_wr_en !== 1'b1 || bus.ext_wr_addr !== 16'hFF46 || bus.ext_wr_data !== 8'hC1) begin
            n_fail++; $display("FAIL ff46_fwd_write got=%b/%h/%h exp=1/FF46/C1", bus.ext_wr_en, bus.ext_wr_addr, bus.ext_wr_data);
        end
        step();
        n_checks++; if (bus.cpu_rd_data !== ext_mem[16'hFF46]) begin n_fail++; $display("FAIL ff46_fwd_read got=%h exp=%h", bus.cpu_rd_data, ext_mem[16'hFF46]); end
        idle_until(cyc + 20);
        n_checks++; if (active_cnt != 0) begin n_fail++; $display("FAIL ff46_no_dma got=%0d exp=0", active_cnt); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 65536; i++) ext_mem[i] = 8'($urandom);
        bus.ext_rd_data = 8'h00;
        test_reset();
        test_hram();
        test_ext_read();
        test_same_addr();
        test_ie();
        test_random();
`ifdef MMU_OAM_DMA_EN
        test_dma();
        test_dma_restart();
        test_dma_echo();
        test_reset_mid_dma();
`else
        test_ff46_forward();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
